// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the RV32I core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and shares one memory port between fetch and load/store.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             ir_wr_en_o,
    output logic             pc_wr_en_o,
    output logic             pc_src_o,
    output logic             reg_wr_en_o,
    output logic             mem_req_o,
    output logic             mem_sel_o,
    output logic             mem_wr_en_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU     = 3'd0,
        C_LOAD    = 3'd1,
        C_STORE   = 3'd2,
        C_BRANCH  = 3'd3,
        C_JUMP    = 3'd4,
        C_ILLEGAL = 3'd5
    } cls_t;

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    cls_t          cls_q;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0000011:                                     classify = C_LOAD;
            7'b0100011:                                     classify = C_STORE;
            7'b1100011:                                     classify = C_BRANCH;
            7'b1101111, 7'b1100111:                         classify = C_JUMP;
            7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111: classify = C_ALU;
            default:                                        classify = C_ILLEGAL;
        endcase
    endfunction

    // Counter runs only while an access waits; any other cycle clears it, so it is
    // already zero whenever FETCH or MEM is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET;
            cls_q         <= C_ALU;
            tmo_cnt       <= '0;
            retired_cnt_o <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                cls_q <= classify(opcode_i);
            end
            if ((state == S_FETCH || state == S_MEM) && !mem_ready_i) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (pc_wr_en_o) begin
                retired_cnt_o <= retired_cnt_o + 1'b1;
            end
        end
    end

    assign timeout_hit = (tmo_cnt == TMO_LAST);
    assign dbg_state   = state;

    // Memory handshake: mem_req_o rises on entry to FETCH/MEM and stays high, with
    // mem_sel_o/mem_wr_en_o constant, until the cycle mem_ready_i is seen; that cycle
    // completes the access. mem_ready_i has no effect in any other state.
    always_comb begin
        next_state  = state;
        ir_wr_en_o  = 1'b0;
        pc_wr_en_o  = 1'b0;
        pc_src_o    = 1'b0;
        reg_wr_en_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_sel_o   = 1'b0;
        mem_wr_en_o = 1'b0;
        trap_o      = 1'b0;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_wr_en_o = 1'b1;
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                next_state = (classify(opcode_i) == C_ILLEGAL) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_BRANCH: begin
                        pc_wr_en_o = 1'b1;
                        pc_src_o   = branch_taken_i;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req_o   = 1'b1;
                mem_sel_o   = 1'b1;
                mem_wr_en_o = (cls_q == C_STORE);
                if (mem_ready_i) begin
                    if (cls_q == C_STORE) begin
                        pc_wr_en_o = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (timeout_hit) begin
                    next_state = S_TRAP;
                end
            end
            S_WB: begin
                reg_wr_en_o = 1'b1;
                pc_wr_en_o  = 1'b1;
                pc_src_o    = (cls_q == C_JUMP);
                next_state  = S_FETCH;
            end
            S_TRAP: trap_o = 1'b1;
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction cycle schedule model feeds an expected
// queue that one negedge process compares against every DUT output each cycle.
module tb_multicycle_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    // Expected-vector flag positions
    localparam int F_IR = 7, F_PCW = 6, F_SRC = 5, F_RW = 4;
    localparam int F_REQ = 3, F_SEL = 2, F_WR = 1, F_TRAP = 0;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_OP = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_FENCE = 7'b0001111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode_i = '0;
    logic          branch_taken_i = 1'b0;
    logic          mem_ready_i = 1'b0;
    logic          ir_wr_en_o, pc_wr_en_o, pc_src_o, reg_wr_en_o;
    logic          mem_req_o, mem_sel_o, mem_wr_en_o, trap_o;
    logic [CW-1:0] retired_cnt_o;
    logic [2:0]    dbg_state;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i),
        .branch_taken_i(branch_taken_i), .mem_ready_i(mem_ready_i),
        .ir_wr_en_o(ir_wr_en_o), .pc_wr_en_o(pc_wr_en_o), .pc_src_o(pc_src_o),
        .reg_wr_en_o(reg_wr_en_o), .mem_req_o(mem_req_o), .mem_sel_o(mem_sel_o),
        .mem_wr_en_o(mem_wr_en_o), .trap_o(trap_o), .retired_cnt_o(retired_cnt_o),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [8+CW-1:0] exp_q[$];
    logic [CW-1:0]   model_cnt = '0;
    logic [6:0]      cur_op = '0;
    logic            cur_taken = 1'b0;
    logic            trapped = 1'b0;
    int              instr_cycles = 0;
    int              checks = 0;
    int              errors = 0;
    int              obs_rw = 0, obs_mreq = 0, obs_src = 0, obs_trap = 0;
    int              base_rw, base_mreq, base_src, base_trap;

    function automatic logic [7:0] fl(input logic ir, pcw, src, rw, req, sel, wr, trp);
        fl = {ir, pcw, src, rw, req, sel, wr, trp};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        logic [6:0] legal[9];
        legal = '{OP_LOAD, OP_OPIMM, OP_STORE, OP_OP, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        is_legal = 1'b0;
        foreach (legal[i]) if (legal[i] == op) is_legal = 1'b1;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [8+CW-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ir_wr_en_o, pc_wr_en_o, pc_src_o, reg_wr_en_o, mem_req_o, mem_sel_o,
                 mem_wr_en_o, trap_o, retired_cnt_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got ir,pcw,src,rw,req,sel,wr,trap=%b cnt=%0d expected %b cnt=%0d",
                         $time, a[8+CW-1:CW], a[CW-1:0], e[8+CW-1:CW], e[CW-1:0]);
            end
            if (reg_wr_en_o === 1'b1) obs_rw++;
            if (mem_req_o === 1'b1 && mem_sel_o === 1'b1) obs_mreq++;
            if (pc_src_o === 1'b1) obs_src++;
            if (trap_o === 1'b1) obs_trap++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic emit(input logic ready, input logic [7:0] flags);
        @(posedge clk);
        #1;
        mem_ready_i    = ready;
        opcode_i       = cur_op;
        branch_taken_i = cur_taken;
        exp_q.push_back({flags, model_cnt});
        if (flags[F_PCW]) model_cnt = model_cnt + 1'b1;
        instr_cycles++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        mem_ready_i = 1'b0;
        model_cnt   = '0;
        trapped     = 1'b0;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('0);
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    // One instruction as a cycle schedule: fw/mw are waiting cycles before ready in
    // fetch/mem; abort_mem ends the task inside MEM after mw waiting cycles.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic taken, input bit abort_mem);
        logic [7:0] mflags;
        bit         is_ld, is_st, is_br, is_j;
        cur_op = op;
        cur_taken = taken;
        instr_cycles = 0;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        is_br = (op == OP_BRANCH);
        is_j  = (op == OP_JAL) || (op == OP_JALR);
        for (int i = 0; i < fw && i < TMO; i++) emit(1'b0, fl(0, 0, 0, 0, 1, 0, 0, 0));
        if (fw >= TMO) begin trapped = 1'b1; return; end
        emit(1'b1, fl(1, 0, 0, 0, 1, 0, 0, 0));
        emit(1'b1, fl(0, 0, 0, 0, 0, 0, 0, 0));
        if (!is_legal(op)) begin trapped = 1'b1; return; end
        if (is_br) begin
            emit(1'b1, fl(0, 1, taken, 0, 0, 0, 0, 0));
            return;
        end
        emit(1'b1, fl(0, 0, 0, 0, 0, 0, 0, 0));
        if (is_ld || is_st) begin
            mflags = fl(0, 0, 0, 0, 1, 1, is_st, 0);
            for (int i = 0; i < mw && i < TMO; i++) emit(1'b0, mflags);
            if (abort_mem) return;
            if (mw >= TMO) begin trapped = 1'b1; return; end
            if (is_st) begin
                emit(1'b1, mflags | fl(0, 1, 0, 0, 0, 0, 0, 0));
                return;
            end
            emit(1'b1, mflags);
        end
        emit(1'b1, fl(0, 1, is_j, 1, 0, 0, 0, 0));
    endtask

    task automatic hold_trap(input int n);
        for (int i = 0; i < n; i++) begin
            cur_op = 7'($urandom_range(0, 127));
            emit(1'($urandom_range(0, 1)), fl(0, 0, 0, 0, 0, 0, 0, 1));
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        do_reset();

        // ADD, zero wait
        base_rw = obs_rw;
        run_instr(OP_OP, 0, 0, 1'b0, 1'b0);
        sync();
        check("add_cycles", instr_cycles, 4);
        check("add_retired_model", int'(model_cnt), 1);
        check("add_reg_writes", obs_rw - base_rw, 1);

        // LW: data ready after 3 waits
        base_mreq = obs_mreq;
        base_rw = obs_rw;
        run_instr(OP_LOAD, 0, 3, 1'b0, 1'b0);
        sync();
        check("lw_cycles", instr_cycles, 8);
        check("lw_mem_req_cycles", obs_mreq - base_mreq, 4);
        check("lw_reg_writes", obs_rw - base_rw, 1);

        // BEQ taken, BNE not taken
        base_src = obs_src;
        base_rw = obs_rw;
        run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0);
        run_instr(OP_BRANCH, 1, 0, 1'b0, 1'b0);
        sync();
        check("branch_cycles", instr_cycles, 4);
        check("branch_src_cycles", obs_src - base_src, 1);
        check("branch_reg_writes", obs_rw - base_rw, 0);
        check("branch_retired_model", int'(model_cnt), 4);

        // Remaining legal classes with wait states
        base_src = obs_src;
        run_instr(OP_OPIMM, 2, 0, 1'b0, 1'b0);
        run_instr(OP_LUI, 1, 0, 1'b1, 1'b0);
        run_instr(OP_AUIPC, 0, 0, 1'b0, 1'b0);
        run_instr(OP_JAL, 3, 0, 1'b0, 1'b0);
        run_instr(OP_JALR, 0, 0, 1'b1, 1'b0);
        run_instr(OP_STORE, 2, 1, 1'b0, 1'b0);
        run_instr(OP_STORE, 0, 0, 1'b0, 1'b0);
        sync();
        check("store_cycles", instr_cycles, 4);
        check("jump_src_cycles", obs_src - base_src, 2);
        check("mixed_retired_model", int'(model_cnt), 11);

        // Illegal opcode traps and holds until reset
        base_trap = obs_trap;
        run_instr(OP_FENCE, 0, 0, 1'b0, 1'b0);
        check("illegal_traps", int'(trapped), 1);
        hold_trap(20);
        sync();
        check("illegal_trap_cycles", obs_trap - base_trap, 20);
        do_reset();
        run_instr(OP_OP, 0, 0, 1'b0, 1'b0);

        // Fetch timeout, then ready on the last allowed wait cycle
        base_trap = obs_trap;
        run_instr(OP_OP, 10, 0, 1'b0, 1'b0);
        hold_trap(3);
        sync();
        check("fetch_timeout_trap_cycles", obs_trap - base_trap, 3);
        do_reset();
        base_trap = obs_trap;
        run_instr(OP_OP, TMO - 1, 0, 1'b0, 1'b0);
        run_instr(OP_LOAD, 0, TMO - 1, 1'b0, 1'b0);
        sync();
        check("ready_on_last_wait_no_trap", obs_trap - base_trap, 0);

        // Memory-phase timeout
        run_instr(OP_LOAD, 0, TMO, 1'b0, 1'b0);
        hold_trap(2);
        do_reset();

        // Reset in the middle of a store
        run_instr(OP_OP, 0, 0, 1'b0, 1'b0);
        run_instr(OP_STORE, 0, 2, 1'b0, 1'b1);
        do_reset();
        sync();
        check("reset_mid_store_req", int'(mem_req_o), 0);
        check("reset_mid_store_cnt", int'(retired_cnt_o), 0);

        // 16 jumps wrap the 4-bit counter
        for (int i = 0; i < 16; i++) run_instr((i % 2 == 0) ? OP_JAL : OP_JALR, 0, 0, 1'b0, 1'b0);
        check("wrap_model", int'(model_cnt), 0);
        run_instr(OP_OP, 0, 0, 1'b0, 1'b0);
        sync();
        check("wrap_dut_cnt", int'(retired_cnt_o), 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
